mux_scan_ctrl: RTL and testbench

- Sequencer directly upstream of the team's 4:1 mux: drives the mux's 2-bit select, waits a programmable settle time per channel, then captures the mux's 1-bit output.
- On a start pulse it scans every channel enabled in a 4-bit mask, lowest index first.
- It assembles the captured bits into a 4-bit sample word and pulses done when the scan completes.

---
 rtl/mux_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan sequencer for a 4:1 mux.
// On an accepted start it steps the mux select through every channel enabled
// in the latched mask (lowest index first), holds each select for DWELL
// cycles, captures the mux output into the matching sample bit and pulses
// done once the last enabled channel has been captured.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] chan_mask,
   input  logic       mux_f,
   output logic [1:0] select,
   output logic       busy,
   output logic       done,
   output logic [3:0] sample
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Reload value for the dwell counter: a channel is held for DWELL cycles,
   // capture happens on the edge where the counter is already zero.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

   state_t           state_q, state_d;
   logic [1:0]       select_q, select_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [3:0]       sample_q, sample_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       mask_q, mask_d;

   logic [1:0]       first_idx;
   logic [2:0]       next_info;

   // Index of the lowest set bit of a non-zero mask (0 if the mask is empty).
   function automatic logic [1:0] lowest_idx(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (m[k]) r = 2'(k);
      end
      return r;
   endfunction

   // {found, index} of the lowest set bit strictly above position s.
   function automatic logic [2:0] next_above(input logic [3:0] m,
                                             input logic [1:0] s);
      logic [2:0] r;
      r = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         if ((k > int'(s)) && m[k]) r = {1'b1, 2'(k)};
      end
      return r;
   endfunction

   assign first_idx = lowest_idx(chan_mask);
   assign next_info = next_above(mask_q, select_q);

   // State register; reset abandons any scan immediately, without a done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         select_q <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sample_q <= 4'b0000;
         cnt_q    <= '0;
         mask_q   <= 4'b0000;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sample_q <= sample_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
      end
   end

   // Next-state logic: accept start in IDLE, dwell/capture/advance in SCAN.
   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sample_d = sample_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               sample_d = 4'b0000;
               if (chan_mask != 4'b0000) begin
                  mask_d   = chan_mask;
                  select_d = first_idx;
                  cnt_d    = CNT_LOAD;
                  busy_d   = 1'b1;
                  state_d  = SCAN;
               end else begin
                  // Empty mask: nothing to scan, report completion at once.
                  done_d = 1'b1;
               end
            end
         end

         SCAN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               sample_d[select_q] = mux_f;
               if (next_info[2]) begin
                  select_d = next_info[1:0];
                  cnt_d    = CNT_LOAD;
               end else begin
                  // Last enabled channel captured; select stays on it.
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign select = select_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign sample = sample_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one DWELL=4 instance for the main scan
// scenarios and one DWELL=1 instance for back-to-back scanning.
module tb_mux_scan_ctrl;

   logic       clk;
   logic       reset;

   logic       start;
   logic [3:0] chan_mask;
   logic [3:0] data;
   logic       mux_f;
   logic [1:0] select;
   logic       busy;
   logic       done;
   logic [3:0] sample;

   logic       start1;
   logic [3:0] mask1;
   logic [3:0] data1;
   logic       mux_f1;
   logic [1:0] select1;
   logic       busy1;
   logic       done1;
   logic [3:0] sample1;

   int pass_cnt;
   int total_cnt;

   // Mux model: f = input selected by select (bit k of data = channel k).
   assign mux_f  = data[select];
   assign mux_f1 = data1[select1];

   mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .chan_mask (chan_mask),
      .mux_f     (mux_f),
      .select    (select),
      .busy      (busy),
      .done      (done),
      .sample    (sample)
   );

   mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .start     (start1),
      .chan_mask (mask1),
      .mux_f     (mux_f1),
      .select    (select1),
      .busy      (busy1),
      .done      (done1),
      .sample    (sample1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total_cnt++;
      if (select !== 2'b00) $display("FAIL reset_select actual=%b required=00", select);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy);
      else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_done actual=%b required=0", done);
      else pass_cnt++;
      total_cnt++;
      if (sample !== 4'b0000) $display("FAIL reset_sample actual=%b required=0000", sample);
      else pass_cnt++;
      total_cnt++;
      if ({select1, busy1, done1, sample1} !== 8'h00)
         $display("FAIL reset_dwell1 actual=%h required=00", {select1, busy1, done1, sample1});
      else pass_cnt++;
      reset = 1'b0;
      tick();
   endtask

   // Mask 1111, channels a=1 b=0 c=1 d=0; optional mid-scan disturbance.
   task automatic run_scan_1111(input bit disturb, input string tag);
      logic [3:0] exp;
      data      = 4'b0101;
      chan_mask = 4'b1111;
      start     = 1'b1;
      tick();                       // edge E0
      start = 1'b0;
      for (int c = 0; c < 16; c++) begin
         exp = {2'(c / 4), 1'b1, 1'b0};
         total_cnt++;
         if ({select, busy, done} !== exp)
            $display("FAIL %s_cycle%0d actual sel/busy/done=%b required=%b",
                     tag, c, {select, busy, done}, exp);
         else pass_cnt++;
         if (disturb) begin
            start     = (c == 5 || c == 6) ? 1'b1 : 1'b0;
            chan_mask = (c >= 5 && c <= 9) ? 4'b0001 : 4'b1111;
         end
         tick();
      end
      // Edge E0+16: scan complete.
      total_cnt++;
      if ({select, busy, done} !== 4'b1101)
         $display("FAIL %s_done actual sel/busy/done=%b required=1101", tag, {select, busy, done});
      else pass_cnt++;
      total_cnt++;
      if (sample !== 4'b0101)
         $display("FAIL %s_sample actual=%b required=0101", tag, sample);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({busy, done} !== 2'b00)
         $display("FAIL %s_after_done actual busy/done=%b required=00", tag, {busy, done});
      else pass_cnt++;
   endtask

   task automatic test_full_scan();
      run_scan_1111(1'b0, "full_scan");
   endtask

   task automatic test_sparse_mask();
      logic [3:0] exp;
      data      = 4'b1111;
      chan_mask = 4'b1010;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
         exp = {(c < 4) ? 2'd1 : 2'd3, 1'b1, 1'b0};
         total_cnt++;
         if ({select, busy, done} !== exp)
            $display("FAIL sparse_cycle%0d actual sel/busy/done=%b required=%b",
                     c, {select, busy, done}, exp);
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if ({select, busy, done} !== 4'b1101)
         $display("FAIL sparse_done actual sel/busy/done=%b required=1101", {select, busy, done});
      else pass_cnt++;
      total_cnt++;
      if (sample !== 4'b1010)
         $display("FAIL sparse_sample actual=%b required=1010", sample);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_empty_mask();
      chan_mask = 4'b0000;
      start     = 1'b1;
      tick();
      start = 1'b0;
      total_cnt++;
      if ({busy, done} !== 2'b01)
         $display("FAIL empty_done actual busy/done=%b required=01", {busy, done});
      else pass_cnt++;
      total_cnt++;
      if (sample !== 4'b0000)
         $display("FAIL empty_sample actual=%b required=0000", sample);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({busy, done} !== 2'b00)
         $display("FAIL empty_after actual busy/done=%b required=00", {busy, done});
      else pass_cnt++;
   endtask

   task automatic test_disturbed_scan();
      run_scan_1111(1'b1, "disturbed");
   endtask

   task automatic test_async_reset();
      data      = 4'b0101;
      chan_mask = 4'b1111;
      start     = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      // Channel 0 (a=1) already captured at E0+4, scan on channel 1.
      total_cnt++;
      if ({select, busy, sample} !== 7'b01_1_0001)
         $display("FAIL midscan_state actual sel/busy/sample=%b required=0110001", {select, busy, sample});
      else pass_cnt++;
      #2 reset = 1'b1;
      #1;
      total_cnt++;
      if ({select, busy, done, sample} !== 8'h00)
         $display("FAIL async_reset actual sel/busy/done/sample=%b required=00000000",
                  {select, busy, done, sample});
      else pass_cnt++;
      for (int c = 0; c < 2; c++) begin
         tick();
         total_cnt++;
         if ({busy, done} !== 2'b00)
            $display("FAIL reset_hold%0d actual busy/done=%b required=00", c, {busy, done});
         else pass_cnt++;
      end
      reset = 1'b0;
      tick();
      run_scan_1111(1'b0, "post_reset");
   endtask

   task automatic test_back_to_back();
      logic [3:0] vals [3];
      vals[0] = 4'b1001;
      vals[1] = 4'b0001;
      vals[2] = 4'b1000;
      mask1  = 4'b1001;
      data1  = vals[0];
      start1 = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) begin
         total_cnt++;
         if ({select1, busy1, done1} !== 4'b0010)
            $display("FAIL b2b_accept%0d actual sel/busy/done=%b required=0010", s, {select1, busy1, done1});
         else pass_cnt++;
         total_cnt++;
         if (sample1 !== 4'b0000)
            $display("FAIL b2b_clear%0d actual=%b required=0000", s, sample1);
         else pass_cnt++;
         tick();
         total_cnt++;
         if ({select1, busy1, done1} !== 4'b1110)
            $display("FAIL b2b_ch3_%0d actual sel/busy/done=%b required=1110", s, {select1, busy1, done1});
         else pass_cnt++;
         tick();
         total_cnt++;
         if ({select1, busy1, done1} !== 4'b1101)
            $display("FAIL b2b_done%0d actual sel/busy/done=%b required=1101", s, {select1, busy1, done1});
         else pass_cnt++;
         total_cnt++;
         if (sample1 !== vals[s])
            $display("FAIL b2b_sample%0d actual=%b required=%b", s, sample1, vals[s]);
         else pass_cnt++;
         if (s < 2) data1 = vals[s + 1];
         else start1 = 1'b0;
         tick();
      end
      total_cnt++;
      if ({busy1, done1} !== 2'b00)
         $display("FAIL b2b_stop actual busy/done=%b required=00", {busy1, done1});
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      reset     = 1'b1;
      start     = 1'b0;
      chan_mask = 4'b0000;
      data      = 4'b0000;
      start1    = 1'b0;
      mask1     = 4'b0000;
      data1     = 4'b0000;
      tick();
      tick();
      test_reset();
      test_full_scan();
      test_sparse_mask();
      test_empty_mask();
      test_disturbed_scan();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
